pipeline_perf_monitor: RTL

//  Hardware performance monitor; consumes the CPU pipeline's status outputs (qualified stall,
//  IF flush, PC) and replaces bench-side software stall/flush counting. Counts run cycles,

---
 rtl/pipeline_perf_monitor_if.sv | 28 ++
 rtl/pipeline_perf_monitor.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pipeline_perf_monitor_if.sv
// Status/readout bundle between the CPU pipeline taps and the performance monitor.
// Trace signals exist only when PERF_PC_TRACE_EN is defined.
interface pipeline_perf_monitor_if #(parameter int CNT_W = 32);
  logic             start_i;
  logic             stall_i;
  logic             flush_i;
  logic [31:0]      pc_i;
  logic             clear_i;
  logic [1:0]       sel_i;
  logic [CNT_W-1:0] data_o;
  logic             done_o;
  logic [1:0]       state_o;
`ifdef PERF_PC_TRACE_EN
  logic             trace_rd_i;
  logic [31:0]      trace_pc_o;
  logic             trace_empty_o;

  modport slave  (input  start_i, stall_i, flush_i, pc_i, clear_i, sel_i, trace_rd_i,
                  output data_o, done_o, state_o, trace_pc_o, trace_empty_o);
  modport master (output start_i, stall_i, flush_i, pc_i, clear_i, sel_i, trace_rd_i,
                  input  data_o, done_o, state_o, trace_pc_o, trace_empty_o);
`else
  modport slave  (input  start_i, stall_i, flush_i, pc_i, clear_i, sel_i,
                  output data_o, done_o, state_o);
  modport master (output start_i, stall_i, flush_i, pc_i, clear_i, sel_i,
                  input  data_o, done_o, state_o);
`endif
endinterface

// File: rtl/pipeline_perf_monitor.sv
// Pipeline performance monitor: saturating run/stall/flush/PC-change counters with a cycle budget.
// Optional PC trace ring enabled by defining PERF_PC_TRACE_EN.
module pipeline_perf_monitor #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 65
`ifdef PERF_PC_TRACE_EN
  , parameter int TRACE_DEPTH = 8
`endif
) (
  input logic                     clk_i,
  input logic                     rst_i,
  pipeline_perf_monitor_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic             r_done;
  logic [CNT_W-1:0] r_cyc, r_stl, r_fls, r_pcc, r_data;
  logic [31:0]      r_pc_prev;
  logic             w_count, w_pc_chg, w_hit;
  logic [CNT_W-1:0] w_cyc_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + CNT_ONE : v;
  endfunction

  assign w_count   = (r_state == S_RUN) && bus.start_i;
  assign w_pc_chg  = (bus.pc_i != r_pc_prev);
  assign w_cyc_nxt = sat_inc(r_cyc, 1'b1);
  // Budget compared on the post-increment value so DONE lands on the MAX_CYCLES-th run edge
  assign w_hit     = (MAX_CYCLES != 0) && (64'(w_cyc_nxt) == 64'(MAX_CYCLES));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_done    <= 1'b0;
      r_cyc     <= '0;
      r_stl     <= '0;
      r_fls     <= '0;
      r_pcc     <= '0;
      r_pc_prev <= '0;
    end else if (bus.clear_i) begin
      r_state   <= S_IDLE;
      r_done    <= 1'b0;
      r_cyc     <= '0;
      r_stl     <= '0;
      r_fls     <= '0;
      r_pcc     <= '0;
      r_pc_prev <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.start_i) r_state <= S_RUN;
        S_RUN:   if (w_count && w_hit) begin
                   r_state <= S_DONE;
                   r_done  <= 1'b1;
                 end
        default: ;
      endcase
      if (w_count) begin
        r_cyc     <= w_cyc_nxt;
        r_stl     <= sat_inc(r_stl, bus.stall_i);
        r_fls     <= sat_inc(r_fls, bus.flush_i);
        r_pcc     <= sat_inc(r_pcc, w_pc_chg);
        r_pc_prev <= bus.pc_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_data <= '0;
    else begin
      case (bus.sel_i)
        2'd0:    r_data <= r_cyc;
        2'd1:    r_data <= r_stl;
        2'd2:    r_data <= r_fls;
        default: r_data <= r_pcc;
      endcase
    end
  end

  assign bus.data_o  = r_data;
  assign bus.done_o  = r_done;
  assign bus.state_o = r_state;

`ifdef PERF_PC_TRACE_EN
  localparam int            AW       = $clog2(TRACE_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT1     = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(TRACE_DEPTH);

  logic [TRACE_DEPTH-1:0][31:0] r_mem;
  logic [AW-1:0]                r_wp, r_rp;
  logic [AW:0]                  r_tcnt;
  logic                         w_push, w_pop, w_full;

  assign w_push = w_count && w_pc_chg;
  assign w_pop  = bus.trace_rd_i && (r_tcnt != '0);
  assign w_full = (r_tcnt == FULL_CNT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mem  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_tcnt <= '0;
    end else if (bus.clear_i) begin
      r_mem  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_tcnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= bus.pc_i;
        r_wp        <= r_wp + PTR_ONE;
      end
      // A push into a full ring drops the oldest entry, same as an explicit pop
      if (w_pop || (w_push && w_full)) r_rp <= r_rp + PTR_ONE;
      if (w_push && !w_pop && !w_full) r_tcnt <= r_tcnt + CNT1;
      else if (w_pop && !w_push)       r_tcnt <= r_tcnt - CNT1;
    end
  end

  assign bus.trace_empty_o = (r_tcnt == '0);
  assign bus.trace_pc_o    = (r_tcnt == '0) ? 32'h0 : r_mem[r_rp];
`endif
endmodule
